int_alu_master: RTL and testbench
=================================

# int_alu_master

Bus initiator that drives the integer ALU's memory-mapped register window on behalf of the execution unit. It accepts one operation per handshake and writes both operands and the opcode over the shared address/nRead/nWrite bus. It then polls the ALU status register, reads back the 256-bit result, and returns it with a done pulse. It sits between the execute stage and the integer ALU and is the only master of the ALU register window.

## Interface
- `ALU_SEL`, default 4'h1: value of address[15:12] that selects the integer ALU.
- `POLL_LIMIT`, default 16: maximum status reads before the operation is abandoned.
- `Clk`  in  1  single clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  8  opcode: 8'h10 ADD, 8'h11 SUB, 8'h12 MULT, 8'h13 DIV.
- `opnd_a`  in  256  first operand (minuend / dividend).
- `opnd_b`  in  256  second operand (subtrahend / divisor).
- `busy`  out  1  high from the cycle after start acceptance until DONE/ERR exits.
- `done`  out  1  one-cycle pulse; `result` valid in the same cycle.
- `err`  out  1  one-cycle pulse on illegal opcode or poll timeout.
- `result`  out  256  registered result; holds until the next done.
- `address`  out  16  bus address, {ALU_SEL, 12-bit register offset}.
- `nWrite`  out  1  active-low write strobe.
- `nRead`  out  1  active-low read strobe.
- `ExeDataOut`  out  256  write data.
- `IntDataOut`  in  256  read data from the ALU, valid combinationally during nRead low.

## Operation
- Register offsets: 0 source_1, 1 source_2, 2 result, 3 status_in, 4 status_out (bit0 = result ready).
- Operand mapping:
  - ADD, SUB, MULT: source_1 = opnd_a, source_2 = opnd_b.
  - DIV: source_1 = opnd_b, source_2 = opnd_a, because the ALU computes source_2/source_1. The result is therefore opnd_a/opnd_b.
- FSM states: IDLE, WR_S1, WR_S2, WR_OP, POLL, RD_RES, DONE, ERR.
- IDLE:
  - start with a legal op: latch op and operands, go to WR_S1.
  - start with an illegal op: go to ERR. No bus activity occurs.
- WR_S1 and WR_S2: nWrite=0, address offset 0 and 1 respectively, ExeDataOut = mapped operand.
- WR_OP: nWrite=0, offset 3, ExeDataOut = {248'b0, op}.
- POLL:
  - nRead=0, offset 4; IntDataOut[0] is sampled at the clock edge.
  - If 1: go to RD_RES.
  - Else: increment the poll counter. Reaching POLL_LIMIT reads goes to ERR; otherwise stay in POLL.
- RD_RES: nRead=0, offset 2; IntDataOut is captured into `result`. Go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE. `result` is unchanged.
- Bus rules:
  - nRead and nWrite are never low in the same cycle.
  - Outside access states: nRead=nWrite=1, address=0, ExeDataOut=0.
- start asserted while busy is ignored; there is no queueing.
- Results are full 256-bit wrap-around. No overflow or divide-by-zero detection; divide-by-zero returns whatever the ALU returns.

## Timing
- All outputs are registered state decodes.
- Reset values: state IDLE, busy 0, done 0, err 0, result 0, address 16'h0000, nWrite 1, nRead 1, ExeDataOut 0, poll counter 0.
- Latency when the first poll succeeds:
  - start accepted at edge 0.
  - WR_S1 in cycle 1, WR_S2 in cycle 2, WR_OP in cycle 3, POLL in cycle 4, RD_RES in cycle 5.
  - done in cycle 6: 6 cycles start-to-done.
- Each extra poll adds 1 cycle. Timeout gives err in cycle 4+POLL_LIMIT.
- Next start is accepted in the cycle after DONE or ERR, when the FSM is back in IDLE.
- Reset mid-operation:
  - Strobes deassert immediately (asynchronously) and the FSM returns to IDLE.
  - No done or err is produced.
  - ALU registers are left as written.

## Structure
- Shared package `alu_bus_pkg` holds:
  - ALU_SEL default.
  - Register-offset constants.
  - Opcode constants ADD/SUB/MULT/DIV.
  - State enum typedef.
- The package is also imported by the ALU.
- No sub-module: the FSM, poll counter and output registers stay flat in one module.

## Test plan
- ADD with opnd_a=5, opnd_b=3 → writes to offsets 0, 1, 3 in cycles 1–3; done in cycle 6; result=8.
- SUB with opnd_a=0, opnd_b=1 → result = 256'hFFFF…FFFF (all ones, wrap-around); err stays 0.
- DIV with opnd_a=100, opnd_b=7 → offset-0 write data is 7, offset-1 write data is 100; result=14.
- op=8'h20 → err pulse in cycle 1; nRead and nWrite stay 1 throughout.
- ALU model holding status_out=0 with POLL_LIMIT=16 → exactly 16 status reads, then an err pulse; result unchanged.
- Reset asserted during WR_S2 → nWrite=1 before the next edge; busy=0; a start afterwards completes normally.

Source files
------------

// File: rtl/alu_bus_pkg.sv
// Shared definitions for the integer ALU register window: select nibble,
// register map, opcodes and the initiator state encoding.
package alu_bus_pkg;

    localparam logic [3:0]  ALU_SEL_DEFAULT = 4'h1;

    localparam logic [11:0] OFF_SOURCE_1   = 12'd0;
    localparam logic [11:0] OFF_SOURCE_2   = 12'd1;
    localparam logic [11:0] OFF_RESULT     = 12'd2;
    localparam logic [11:0] OFF_STATUS_IN  = 12'd3;
    localparam logic [11:0] OFF_STATUS_OUT = 12'd4;

    localparam logic [7:0]  OP_ADD  = 8'h10;
    localparam logic [7:0]  OP_SUB  = 8'h11;
    localparam logic [7:0]  OP_MULT = 8'h12;
    localparam logic [7:0]  OP_DIV  = 8'h13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_S1,
        ST_WR_S2,
        ST_WR_OP,
        ST_POLL,
        ST_RD_RES,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic is_legal_op(input logic [7:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB) ||
               (opcode == OP_MULT) || (opcode == OP_DIV);
    endfunction

endpackage

// File: rtl/int_alu_master.sv
// Bus initiator for the integer ALU: writes operands and opcode, polls the
// status register, reads back the 256-bit result and reports done or err.
module int_alu_master
    import alu_bus_pkg::*;
#(
    parameter logic [3:0] ALU_SEL    = ALU_SEL_DEFAULT,
    parameter int         POLL_LIMIT = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic [7:0]   op,
    input  logic [255:0] opnd_a,
    input  logic [255:0] opnd_b,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [255:0] result,
    output logic [15:0]  address,
    output logic         nWrite,
    output logic         nRead,
    output logic [255:0] ExeDataOut,
    input  logic [255:0] IntDataOut
);

    localparam int PCW = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

    state_t         state_reg, state_next;
    logic [PCW-1:0] poll_cnt_reg;
    logic [7:0]     op_reg;
    logic [255:0]   src2_reg;
    logic           accept;

    logic           busy_next, done_next, err_next, nwrite_next, nread_next;
    logic [15:0]    address_next;
    logic [255:0]   exe_data_next;
    logic [11:0]    offset;
    logic           access;

    assign accept = (state_reg == ST_IDLE) && start && is_legal_op(op);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = is_legal_op(op) ? ST_WR_S1 : ST_ERR;
            ST_WR_S1:  state_next = ST_WR_S2;
            ST_WR_S2:  state_next = ST_WR_OP;
            ST_WR_OP:  state_next = ST_POLL;
            ST_POLL: begin
                if (IntDataOut[0])
                    state_next = ST_RD_RES;
                else if (poll_cnt_reg == POLL_LAST)
                    state_next = ST_ERR;
            end
            ST_RD_RES: state_next = ST_DONE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so the bus
    // pins change exactly at the edge that enters each state. WR_S1 is only
    // reached from IDLE, where the operands are still on the inputs.
    always_comb begin
        busy_next     = (state_next != ST_IDLE);
        done_next     = (state_next == ST_DONE);
        err_next      = (state_next == ST_ERR);
        nwrite_next   = 1'b1;
        nread_next    = 1'b1;
        access        = 1'b0;
        offset        = OFF_SOURCE_1;
        exe_data_next = '0;
        case (state_next)
            ST_WR_S1: begin
                nwrite_next   = 1'b0;
                access        = 1'b1;
                offset        = OFF_SOURCE_1;
                exe_data_next = (op == OP_DIV) ? opnd_b : opnd_a;
            end
            ST_WR_S2: begin
                nwrite_next   = 1'b0;
                access        = 1'b1;
                offset        = OFF_SOURCE_2;
                exe_data_next = src2_reg;
            end
            ST_WR_OP: begin
                nwrite_next   = 1'b0;
                access        = 1'b1;
                offset        = OFF_STATUS_IN;
                exe_data_next = {248'b0, op_reg};
            end
            ST_POLL: begin
                nread_next = 1'b0;
                access     = 1'b1;
                offset     = OFF_STATUS_OUT;
            end
            ST_RD_RES: begin
                nread_next = 1'b0;
                access     = 1'b1;
                offset     = OFF_RESULT;
            end
            default: ;
        endcase
        address_next = access ? {ALU_SEL, offset} : 16'h0000;
    end

    // The ALU divides source_2 by source_1, so DIV swaps the operands.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_reg       <= '0;
            src2_reg     <= '0;
            poll_cnt_reg <= '0;
            result       <= '0;
        end else begin
            if (accept) begin
                op_reg   <= op;
                src2_reg <= (op == OP_DIV) ? opnd_a : opnd_b;
            end
            if (state_reg != ST_POLL)
                poll_cnt_reg <= '0;
            else if (!IntDataOut[0])
                poll_cnt_reg <= poll_cnt_reg + 1'b1;
            if (state_reg == ST_RD_RES)
                result <= IntDataOut;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            address    <= 16'h0000;
            nWrite     <= 1'b1;
            nRead      <= 1'b1;
            ExeDataOut <= '0;
        end else begin
            busy       <= busy_next;
            done       <= done_next;
            err        <= err_next;
            address    <= address_next;
            nWrite     <= nwrite_next;
            nRead      <= nread_next;
            ExeDataOut <= exe_data_next;
        end
    end

endmodule

// File: tb/tb_int_alu_master.sv
// Self-checking bench for int_alu_master with a behavioural integer ALU
// attached to its register window and a plain-arithmetic result model.
module tb_int_alu_master;

    localparam logic [7:0] ADD  = 8'h10;
    localparam logic [7:0] SUB  = 8'h11;
    localparam logic [7:0] MULT = 8'h12;
    localparam logic [7:0] DIV  = 8'h13;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   op = '0;
    logic [255:0] opnd_a = '0;
    logic [255:0] opnd_b = '0;
    logic         busy, done, err, nWrite, nRead;
    logic [255:0] result, ExeDataOut, IntDataOut;
    logic [15:0]  address;

    int checks = 0;
    int failures = 0;
    logic [255:0] exp_result = '0;

    logic [15:0]  wr_off [8];
    logic [255:0] wr_dat [8];
    int           wr_cyc [8];
    int           nwr, nrd;

    int_alu_master #(.ALU_SEL(4'h1), .POLL_LIMIT(16)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op(op),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .busy(busy), .done(done),
        .err(err), .result(result), .address(address), .nWrite(nWrite),
        .nRead(nRead), .ExeDataOut(ExeDataOut), .IntDataOut(IntDataOut)
    );

    always #5 Clk = ~Clk;

    // Integer ALU model: register file, computes source_2/source_1 for DIV,
    // and reports ready after a configurable number of not-ready polls.
    logic [255:0] alu_s1 = '0, alu_s2 = '0, alu_res = '0;
    int           alu_wait = 0;
    int           delay_cfg = 0;
    bit           alu_stuck = 1'b0;
    logic         alu_ready;
    assign alu_ready = !alu_stuck && (alu_wait == 0);

    always @(posedge Clk) begin
        if (address[15:12] == 4'h1) begin
            if (!nWrite) begin
                case (address[11:0])
                    12'd0: alu_s1 <= ExeDataOut;
                    12'd1: alu_s2 <= ExeDataOut;
                    12'd3: begin
                        case (ExeDataOut[7:0])
                            ADD:     alu_res <= alu_s1 + alu_s2;
                            SUB:     alu_res <= alu_s1 - alu_s2;
                            MULT:    alu_res <= alu_s1 * alu_s2;
                            DIV:     alu_res <= (alu_s1 == 0) ? '0 : alu_s2 / alu_s1;
                            default: alu_res <= '0;
                        endcase
                        alu_wait <= delay_cfg;
                    end
                    default: ;
                endcase
            end
            if (!nRead && address[11:0] == 12'd4 && alu_wait != 0)
                alu_wait <= alu_wait - 1;
        end
    end

    always_comb begin
        IntDataOut = '0;
        if (!nRead && address[15:12] == 4'h1) begin
            if (address[11:0] == 12'd4)
                IntDataOut = {255'b0, alu_ready};
            else if (address[11:0] == 12'd2)
                IntDataOut = alu_res;
        end
    end

    function automatic logic [255:0] ref_alu(input logic [7:0] o, input logic [255:0] a, input logic [255:0] b);
        case (o)
            ADD:     return a + b;
            SUB:     return a - b;
            MULT:    return a * b;
            DIV:     return (b == 0) ? '0 : a / b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Issues one request and observes it cycle by cycle (cycle 1 = first
    // cycle after the accepting edge) until done, err or the cycle budget.
    task automatic run_op(input logic [7:0] o, input logic [255:0] a, input logic [255:0] b,
                          input int dly, input bit stuck, input bit hold,
                          output logic [255:0] res_o, output int done_c, output int err_c,
                          output int npoll, output int bus_bad);
        int k;
        int w;
        done_c = 0; err_c = 0; npoll = 0; bus_bad = 0; nwr = 0; nrd = 0; res_o = '0;
        delay_cfg = dly;
        alu_stuck = stuck;
        @(negedge Clk);
        w = 0;
        while (busy && w < 20) begin
            @(negedge Clk);
            w++;
        end
        op = o; opnd_a = a; opnd_b = b; start = 1'b1;
        k = 0;
        while (done_c == 0 && err_c == 0 && k < 100) begin
            @(negedge Clk);
            k++;
            if (!hold) start = 1'b0;
            if (!nWrite && !nRead) bus_bad++;
            if (nWrite && nRead && (address != 16'h0 || ExeDataOut != '0)) bus_bad++;
            if (!nWrite && nwr < 8) begin
                wr_off[nwr] = address; wr_dat[nwr] = ExeDataOut; wr_cyc[nwr] = k; nwr++;
            end
            if (!nRead) nrd++;
            if (!nRead && address == 16'h1004) npoll++;
            if (done) begin done_c = k; res_o = result; end
            if (err) err_c = k;
        end
        start = 1'b0;
        if (k >= 100) begin
            checks++; failures++;
            $display("FAIL run_op_timeout: no done/err within 100 cycles for op=%h", o);
        end
    endtask

    task automatic test_reset();
        #1 Reset = 1'b1;
        @(negedge Clk);
        checks += 8;
        if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        if (err !== 1'b0)        begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        if (result !== '0)       begin failures++; $display("FAIL reset_result: got %h want 0", result); end
        if (address !== 16'h0)   begin failures++; $display("FAIL reset_address: got %h want 0", address); end
        if (nWrite !== 1'b1)     begin failures++; $display("FAIL reset_nWrite: got %b want 1", nWrite); end
        if (nRead !== 1'b1)      begin failures++; $display("FAIL reset_nRead: got %b want 1", nRead); end
        if (ExeDataOut !== '0)   begin failures++; $display("FAIL reset_ExeDataOut: got %h want 0", ExeDataOut); end
        Reset = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_add();
        logic [255:0] r; int dc, ec, np, bb;
        logic [15:0] eo[3];
        logic [255:0] ed[3];
        eo[0] = 16'h1000; eo[1] = 16'h1001; eo[2] = 16'h1003;
        ed[0] = 256'd5; ed[1] = 256'd3; ed[2] = 256'h10;
        run_op(ADD, 256'd5, 256'd3, 0, 1'b0, 1'b0, r, dc, ec, np, bb);
        $display("txn add 5+3 done_cyc=%0d result=%0d", dc, r);
        checks++; if (nwr !== 3) begin failures++; $display("FAIL add_nwrites: got %0d want 3", nwr); end
        for (int i = 0; i < 3; i++) begin
            checks += 3;
            if (wr_cyc[i] !== i + 1) begin failures++; $display("FAIL add_wr_cycle%0d: got %0d want %0d", i, wr_cyc[i], i + 1); end
            if (wr_off[i] !== eo[i]) begin failures++; $display("FAIL add_wr_addr%0d: got %h want %h", i, wr_off[i], eo[i]); end
            if (wr_dat[i] !== ed[i]) begin failures++; $display("FAIL add_wr_data%0d: got %h want %h", i, wr_dat[i], ed[i]); end
        end
        checks += 4;
        if (dc !== 6)        begin failures++; $display("FAIL add_done_cycle: got %0d want 6", dc); end
        if (r !== 256'd8)    begin failures++; $display("FAIL add_result: got %h want 8", r); end
        if (np !== 1)        begin failures++; $display("FAIL add_polls: got %0d want 1", np); end
        if (bb !== 0)        begin failures++; $display("FAIL add_bus_rules: got %0d violations want 0", bb); end
        exp_result = 256'd8;
    endtask

    task automatic test_sub_wrap();
        logic [255:0] r; logic [255:0] ones; int dc, ec, np, bb;
        ones = '1;
        run_op(SUB, 256'd0, 256'd1, 0, 1'b0, 1'b0, r, dc, ec, np, bb);
        $display("txn sub 0-1 done_cyc=%0d err_cyc=%0d", dc, ec);
        checks += 3;
        if (r !== ones) begin failures++; $display("FAIL sub_result: got %h want all ones", r); end
        if (ec !== 0)   begin failures++; $display("FAIL sub_err: got err at cycle %0d want none", ec); end
        if (dc !== 6)   begin failures++; $display("FAIL sub_done_cycle: got %0d want 6", dc); end
        exp_result = ones;
    endtask

    task automatic test_div_swap();
        logic [255:0] r; int dc, ec, np, bb;
        run_op(DIV, 256'd100, 256'd7, 0, 1'b0, 1'b0, r, dc, ec, np, bb);
        $display("txn div 100/7 done_cyc=%0d result=%0d", dc, r);
        checks += 3;
        if (wr_dat[0] !== 256'd7)   begin failures++; $display("FAIL div_src1_data: got %0d want 7", wr_dat[0]); end
        if (wr_dat[1] !== 256'd100) begin failures++; $display("FAIL div_src2_data: got %0d want 100", wr_dat[1]); end
        if (r !== 256'd14)          begin failures++; $display("FAIL div_result: got %0d want 14", r); end
        exp_result = 256'd14;
    endtask

    task automatic test_illegal_op();
        logic [255:0] r; int dc, ec, np, bb;
        run_op(8'h20, rand256(), rand256(), 0, 1'b0, 1'b0, r, dc, ec, np, bb);
        $display("txn illegal op=20 err_cyc=%0d", ec);
        checks += 5;
        if (ec !== 1)              begin failures++; $display("FAIL illegal_err_cycle: got %0d want 1", ec); end
        if (dc !== 0)              begin failures++; $display("FAIL illegal_done: got done at %0d want none", dc); end
        if (nwr !== 0 || nrd !== 0) begin failures++; $display("FAIL illegal_bus: got %0d writes %0d reads want 0", nwr, nrd); end
        if (result !== exp_result) begin failures++; $display("FAIL illegal_result_kept: got %h want %h", result, exp_result); end
        if (bb !== 0)              begin failures++; $display("FAIL illegal_bus_rules: got %0d violations want 0", bb); end
    endtask

    task automatic test_poll_timeout();
        logic [255:0] r; int dc, ec, np, bb;
        run_op(MULT, rand256(), rand256(), 0, 1'b1, 1'b0, r, dc, ec, np, bb);
        $display("txn timeout polls=%0d err_cyc=%0d", np, ec);
        checks += 4;
        if (np !== 16)             begin failures++; $display("FAIL timeout_polls: got %0d want 16", np); end
        if (ec !== 20)             begin failures++; $display("FAIL timeout_err_cycle: got %0d want 20", ec); end
        if (dc !== 0)              begin failures++; $display("FAIL timeout_done: got done at %0d want none", dc); end
        if (result !== exp_result) begin failures++; $display("FAIL timeout_result_kept: got %h want %h", result, exp_result); end
    endtask

    task automatic test_random();
        logic [255:0] r, a, b, e; int dc, ec, np, bb, dly;
        logic [7:0] o;
        for (int t = 0; t < 24; t++) begin
            a = rand256();
            b = rand256() >> $urandom_range(0, 250);
            if (b == 0) b = 256'd1;
            dly = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) begin
                do o = 8'($urandom); while (o >= 8'h10 && o <= 8'h13);
            end else begin
                o = 8'h10 + 8'($urandom_range(0, 3));
            end
            run_op(o, a, b, dly, 1'b0, 1'b0, r, dc, ec, np, bb);
            $display("txn rand %0d op=%h dly=%0d done_cyc=%0d err_cyc=%0d", t, o, dly, dc, ec);
            checks += 2;
            if (bb !== 0) begin failures++; $display("FAIL rand_bus_rules: txn %0d got %0d violations want 0", t, bb); end
            if (o >= 8'h10 && o <= 8'h13) begin
                e = ref_alu(o, a, b);
                checks++;
                if (dc !== 6 + dly) begin failures++; $display("FAIL rand_latency: txn %0d got %0d want %0d", t, dc, 6 + dly); end
                if (r !== e)        begin failures++; $display("FAIL rand_result: txn %0d op %h got %h want %h", t, o, r, e); end
                exp_result = e;
            end else begin
                checks++;
                if (ec !== 1) begin failures++; $display("FAIL rand_illegal_err: txn %0d got %0d want 1", t, ec); end
                if (result !== exp_result) begin failures++; $display("FAIL rand_illegal_result: txn %0d got %h want %h", t, result, exp_result); end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [255:0] r, a, b; int dc, ec, np, bb;
        a = rand256(); b = rand256();
        run_op(ADD, a, b, 2, 1'b0, 1'b1, r, dc, ec, np, bb);
        $display("txn busy_ignore done_cyc=%0d writes=%0d", dc, nwr);
        checks += 3;
        if (nwr !== 3)     begin failures++; $display("FAIL busy_ignore_writes: got %0d want 3", nwr); end
        if (dc !== 8)      begin failures++; $display("FAIL busy_ignore_done_cycle: got %0d want 8", dc); end
        if (r !== a + b)   begin failures++; $display("FAIL busy_ignore_result: got %h want %h", r, a + b); end
        exp_result = a + b;
    endtask

    task automatic test_back_to_back();
        logic [255:0] r1, r2, a, b; int dc1, dc2, ec, np, bb;
        a = rand256(); b = rand256();
        run_op(MULT, a, b, 0, 1'b0, 1'b0, r1, dc1, ec, np, bb);
        run_op(SUB, b, a, 1, 1'b0, 1'b0, r2, dc2, ec, np, bb);
        $display("txn back_to_back done_cyc=%0d,%0d", dc1, dc2);
        checks += 3;
        if (r1 !== a * b) begin failures++; $display("FAIL b2b_first_result: got %h want %h", r1, a * b); end
        if (r2 !== b - a) begin failures++; $display("FAIL b2b_second_result: got %h want %h", r2, b - a); end
        if (dc2 !== 7)    begin failures++; $display("FAIL b2b_second_latency: got %0d want 7", dc2); end
        exp_result = b - a;
    endtask

    task automatic test_reset_mid();
        logic [255:0] r; int dc, ec, np, bb; bit pulse;
        @(negedge Clk);
        op = ADD; opnd_a = 256'd9; opnd_b = 256'd4; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        checks++;
        if (nWrite !== 1'b0 || address !== 16'h1001) begin
            failures++; $display("FAIL rstmid_in_wr_s2: got nWrite=%b addr=%h want 0/1001", nWrite, address);
        end
        #2 Reset = 1'b1;
        #1;
        checks += 3;
        if (nWrite !== 1'b1) begin failures++; $display("FAIL rstmid_nWrite: got %b want 1", nWrite); end
        if (busy !== 1'b0)   begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (nRead !== 1'b1)  begin failures++; $display("FAIL rstmid_nRead: got %b want 1", nRead); end
        pulse = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            if (done || err) pulse = 1'b1;
        end
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (done || err) pulse = 1'b1;
        end
        checks++;
        if (pulse !== 1'b0) begin failures++; $display("FAIL rstmid_pulse: got done/err after reset want none"); end
        run_op(ADD, 256'd11, 256'd22, 0, 1'b0, 1'b0, r, dc, ec, np, bb);
        $display("txn after_reset add done_cyc=%0d result=%0d", dc, r);
        checks += 2;
        if (r !== 256'd33) begin failures++; $display("FAIL rstmid_after_result: got %0d want 33", r); end
        if (dc !== 6)      begin failures++; $display("FAIL rstmid_after_latency: got %0d want 6", dc); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_div_swap();
        test_illegal_op();
        test_poll_timeout();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
